// File: rtl/note_seq_pkg.sv
// Shared types and constants for the note_seq scale sequencer.
// Holds the FSM state encoding, C-major frequency table and saturation limits.
package note_seq_pkg;

  typedef enum logic [1:0] {
    MANUAL    = 2'd0,
    AUTO_NOTE = 2'd1,
    AUTO_GAP  = 2'd2
  } state_t;

  localparam int         TIMER_W   = 24;
  localparam logic [2:0] IDX_MAX   = 3'd7;
  localparam logic [1:0] TEMPO_MAX = 2'd3;

  // C4..C5 in Hz, indexed by note_idx
  localparam logic [31:0] FREQ_TBL [8] = '{
    32'd262, 32'd294, 32'd330, 32'd349, 32'd392, 32'd440, 32'd494, 32'd523
  };

endpackage

// File: rtl/note_timer.sv
// Interval timer: counts while enabled, pulses done for one cycle at the limit and self-clears.
// done is combinational from the count; clear has priority over counting.
module note_timer
  import note_seq_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               enable,
  input  logic [TIMER_W-1:0] limit,
  output logic               done
);

  logic [TIMER_W-1:0] count;

  // >= rather than ==: a tempo speed-up can drop the limit below a running count,
  // and that note must end now instead of waiting for the counter to wrap.
  assign done = enable && !clear && (count >= limit);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (done) begin
      count <= '0;
    end else if (enable) begin
      count <= count + TIMER_W'(1);
    end
  end

endmodule

// File: rtl/note_seq.sv
// Scale sequencer: encoder pulses -> freq/onOff for the tone generator, manual or auto-play.
// Outputs registered, 1 clock after the input pulse. NOTE_SEQ_PINGPONG_EN makes auto-play bounce 0..7..0.
module note_seq
  import note_seq_pkg::*;
#(
  parameter int FCLK     = 50000000,
  parameter int NOTE_CYC = 12500000,
  parameter int GAP_CYC  = 1250000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cw,
  input  logic        ccw,
  input  logic        play,
  input  logic        mute,
  output logic [31:0] freq,
  output logic        onOff,
  output logic [2:0]  note_idx,
  output logic        auto_mode
);

  if (FCLK <= 0) begin : g_bad_fclk
    $error("note_seq: FCLK must be positive");
  end
  // Shortest note is NOTE_CYC >> 3, so it must still be at least one clock.
  if (NOTE_CYC < 8 || NOTE_CYC > (1 << TIMER_W)) begin : g_bad_note
    $error("note_seq: NOTE_CYC does not fit the 24-bit timer");
  end
  if (GAP_CYC < 1 || GAP_CYC > (1 << TIMER_W)) begin : g_bad_gap
    $error("note_seq: GAP_CYC does not fit the 24-bit timer");
  end

  localparam logic [TIMER_W-1:0] GAP_LIM = TIMER_W'(GAP_CYC - 1);

  state_t             state;
  logic [1:0]         tempo;
  logic               step_up, step_dn;
  logic               tmr_clear, tmr_en, tmr_done;
  logic [TIMER_W-1:0] note_lim, tmr_limit;
  logic [2:0]         idx_adv, idx_nxt;
`ifdef NOTE_SEQ_PINGPONG_EN
  logic               dir_down, dir_adv;
`endif

  assign step_up   = cw && !ccw;
  assign step_dn   = ccw && !cw;
  assign note_lim  = TIMER_W'((NOTE_CYC >> tempo) - 1);
  assign tmr_limit = (state == AUTO_NOTE) ? note_lim : GAP_LIM;
  assign tmr_en    = (state != MANUAL);
  assign tmr_clear = (state == MANUAL) || play;

  note_timer u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmr_clear),
    .enable (tmr_en),
    .limit  (tmr_limit),
    .done   (tmr_done)
  );

  always_comb begin
`ifdef NOTE_SEQ_PINGPONG_EN
    dir_adv = dir_down;
    if (!dir_down) begin
      if (note_idx == IDX_MAX) begin
        idx_adv = IDX_MAX - 3'd1;
        dir_adv = 1'b1;
      end else begin
        idx_adv = note_idx + 3'd1;
      end
    end else if (note_idx == 3'd0) begin
      idx_adv = 3'd1;
      dir_adv = 1'b0;
    end else begin
      idx_adv = note_idx - 3'd1;
    end
`else
    idx_adv = note_idx + 3'd1;
`endif
  end

  // play outranks both encoder steps and gap expiry.
  always_comb begin
    idx_nxt = note_idx;
    if (!play) begin
      case (state)
        MANUAL: begin
          if (step_up && note_idx != IDX_MAX)
            idx_nxt = note_idx + 3'd1;
          else if (step_dn && note_idx != 3'd0)
            idx_nxt = note_idx - 3'd1;
        end
        AUTO_GAP: begin
          if (tmr_done)
            idx_nxt = idx_adv;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= MANUAL;
      note_idx  <= 3'd0;
      freq      <= FREQ_TBL[0];
      onOff     <= 1'b0;
      auto_mode <= 1'b0;
      tempo     <= 2'd0;
`ifdef NOTE_SEQ_PINGPONG_EN
      dir_down  <= 1'b0;
`endif
    end else begin
      note_idx <= idx_nxt;
      freq     <= FREQ_TBL[idx_nxt];

      if (state != MANUAL && !play) begin
        if (step_up && tempo != TEMPO_MAX)
          tempo <= tempo + 2'd1;
        else if (step_dn && tempo != 2'd0)
          tempo <= tempo - 2'd1;
      end

      case (state)
        MANUAL: begin
          onOff <= ~mute;
          if (play) begin
            state     <= AUTO_NOTE;
            auto_mode <= 1'b1;
`ifdef NOTE_SEQ_PINGPONG_EN
            dir_down  <= 1'b0;
`endif
          end
        end
        AUTO_NOTE: begin
          if (play) begin
            state     <= MANUAL;
            auto_mode <= 1'b0;
            onOff     <= ~mute;
          end else if (tmr_done) begin
            state <= AUTO_GAP;
            onOff <= 1'b0;
          end else begin
            onOff <= ~mute;
          end
        end
        AUTO_GAP: begin
          if (play) begin
            state     <= MANUAL;
            auto_mode <= 1'b0;
            onOff     <= ~mute;
          end else if (tmr_done) begin
            state <= AUTO_NOTE;
            onOff <= ~mute;
`ifdef NOTE_SEQ_PINGPONG_EN
            dir_down <= dir_adv;
`endif
          end else begin
            onOff <= 1'b0;
          end
        end
        default: begin
          state <= MANUAL;
          onOff <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_seq.sv
// Self-checking bench for note_seq with short note/gap lengths (NOTE_CYC=8, GAP_CYC=2).
module tb_note_seq;

  localparam int NOTE_CYC = 8;
  localparam int GAP_CYC  = 2;

  logic        clk = 1'b0;
  logic        reset, cw, ccw, play, mute;
  logic [31:0] freq;
  logic        onOff;
  logic [2:0]  note_idx;
  logic        auto_mode;

  note_seq #(.NOTE_CYC(NOTE_CYC), .GAP_CYC(GAP_CYC)) dut (
    .clk(clk), .reset(reset), .cw(cw), .ccw(ccw), .play(play), .mute(mute),
    .freq(freq), .onOff(onOff), .note_idx(note_idx), .auto_mode(auto_mode)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] idx;
    logic       on;
    logic       am;
  } exp_t;

  typedef struct packed {
    logic       cw, ccw, play, mute;
    logic [2:0] idx;
    logic       on;
  } vec_t;

  int unsigned tb_freq [8] = '{262, 294, 330, 349, 392, 440, 494, 523};
  exp_t sbq[$];
  vec_t tbl [32];
  int   ntbl;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 unit after the rising edge.
  task automatic drive(input logic c, input logic cc, input logic p, input logic m);
    @(negedge clk);
    cw = c; ccw = cc; play = p; mute = m;
    @(posedge clk);
    #1;
    cw = 1'b0; ccw = 1'b0; play = 1'b0;
  endtask

  task automatic step_exp(input logic c, input logic cc, input logic p, input logic m,
                          input logic [2:0] idx, input logic on, input logic am,
                          input string name);
    exp_t e;
    e.idx = idx; e.on = on; e.am = am;
    sbq.push_back(e);
    drive(c, cc, p, m);
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty", name);
    end else begin
      e = sbq.pop_front();
      chk({name, "_idx"},  32'(note_idx), 32'(e.idx));
      chk({name, "_freq"}, freq, tb_freq[e.idx]);
      chk({name, "_on"},   32'(onOff), 32'(e.on));
      chk({name, "_auto"}, 32'(auto_mode), 32'(e.am));
    end
  endtask

  task automatic add_vec(input logic c, input logic cc, input logic m,
                         input logic [2:0] idx, input logic on);
    tbl[ntbl] = {c, cc, 1'b0, m, idx, on};
    ntbl++;
  endtask

  // Finds the next rising edge of onOff, then measures that note and the following gap.
  task automatic measure(output int hi, output int lo, output bit ok);
    logic prev;
    hi = 0; lo = 0; ok = 1'b0;
    prev = onOff;
    for (int n = 0; n < 100; n++) begin
      drive(1'b0, 1'b0, 1'b0, mute);
      if (onOff && !prev) begin ok = 1'b1; break; end
      prev = onOff;
    end
    if (ok) begin
      hi = 1;
      for (int n = 0; n < 100; n++) begin
        drive(1'b0, 1'b0, 1'b0, mute);
        if (onOff) hi++; else break;
      end
      lo = 1;
      for (int n = 0; n < 100; n++) begin
        drive(1'b0, 1'b0, 1'b0, mute);
        if (!onOff) lo++; else break;
      end
    end
  endtask

  function automatic logic [2:0] exp_note(input int k);
`ifdef NOTE_SEQ_PINGPONG_EN
    return (k <= 7) ? 3'(k) : 3'(14 - k);
`else
    return 3'(k % 8);
`endif
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, lo, per, bad;
    bit ok;
    logic prev;
    logic [2:0] held, pidx;

    reset = 1'b1; cw = 1'b0; ccw = 1'b0; play = 1'b0; mute = 1'b0;

    for (int i = 0; i < 3; i++)
      step_exp(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, $sformatf("reset%0d", i));
    reset = 1'b0;
    step_exp(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, "release");

    // Manual-mode vector table
    ntbl = 0;
    for (int i = 0; i < 9; i++) add_vec(1'b1, 1'b0, 1'b0, (i < 6) ? 3'(i + 1) : 3'd7, 1'b1);
    add_vec(1'b1, 1'b1, 1'b0, 3'd7, 1'b1);
    add_vec(1'b0, 1'b1, 1'b0, 3'd6, 1'b1);
    add_vec(1'b0, 1'b0, 1'b1, 3'd6, 1'b0);
    add_vec(1'b0, 1'b0, 1'b0, 3'd6, 1'b1);
    for (int i = 0; i < 7; i++) add_vec(1'b0, 1'b1, 1'b0, (i < 6) ? 3'(5 - i) : 3'd0, 1'b1);
    add_vec(1'b1, 1'b1, 1'b0, 3'd0, 1'b1);
    for (int i = 0; i < ntbl; i++)
      step_exp(tbl[i].cw, tbl[i].ccw, tbl[i].play, tbl[i].mute,
               tbl[i].idx, tbl[i].on, 1'b0, $sformatf("vec%0d", i));

    // Auto play: 10 notes of 8 on + 2 off, starting from index 0
    for (int k = 0; k < 10; k++)
      for (int c = 0; c < NOTE_CYC + GAP_CYC; c++)
        step_exp(1'b0, 1'b0, (k == 0 && c == 0), 1'b0, exp_note(k), (c < NOTE_CYC), 1'b1,
                 $sformatf("auto_n%0d_c%0d", k, c));

    // Tempo saturates at 3: 1-clock notes
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
    measure(hi, lo, ok);
    chk("tempo3_found", 32'(ok), 32'd1);
    chk("tempo3_note", hi, 1);
    chk("tempo3_gap", lo, GAP_CYC);

    drive(1'b0, 1'b1, 1'b0, 1'b0);
    measure(hi, lo, ok);
    chk("tempo2_found", 32'(ok), 32'd1);
    chk("tempo2_note", hi, 2);
    chk("tempo2_gap", lo, GAP_CYC);

    // Mute keeps onOff low without changing note timing
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    pidx = note_idx; ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      if (note_idx != pidx) begin ok = 1'b1; break; end
    end
    pidx = note_idx; per = 0; bad = 0;
    for (int n = 0; n < 50; n++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      per++;
      if (onOff) bad++;
      if (note_idx != pidx) break;
    end
    chk("mute_found", 32'(ok), 32'd1);
    chk("mute_period", per, 2 + GAP_CYC);
    chk("mute_onoff_high_cycles", bad, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    // play on the final gap cycle: back to manual, no advance
    prev = onOff; ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      if (!onOff && prev) begin ok = 1'b1; break; end
      prev = onOff;
    end
    chk("gap_found", 32'(ok), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    held = note_idx;
    step_exp(1'b0, 1'b0, 1'b1, 1'b0, held, 1'b1, 1'b0, "play_at_gap_end");
    step_exp(1'b0, 1'b0, 1'b0, 1'b0, held, 1'b1, 1'b0, "manual_hold");

    // Tempo survives the mode switch
    step_exp(1'b0, 1'b0, 1'b1, 1'b0, held, 1'b1, 1'b1, "reenter_auto");
    measure(hi, lo, ok);
    chk("tempo_kept_found", 32'(ok), 32'd1);
    chk("tempo_kept_note", hi, 2);

    // Reset in the middle of a note
    reset = 1'b1;
    step_exp(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, "reset_mid_note");
    reset = 1'b0;
    step_exp(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, "after_reset");
    step_exp(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, "play_beats_cw");
    measure(hi, lo, ok);
    chk("tempo_cleared_found", 32'(ok), 32'd1);
    chk("tempo_cleared_note", hi, NOTE_CYC);
    chk("tempo_cleared_gap", lo, GAP_CYC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
